// File: rtl/store_pkg.sv
// Shared encodings and helpers for the store-side memory unit.
package store_pkg;

  typedef enum logic [1:0] {
    ST_SW   = 2'b00,
    ST_SH   = 2'b01,
    ST_SB   = 2'b10,
    ST_SWRR = 2'b11
  } st_type_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_MRG  = 3'd2,
    S_WR   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Latched request fields; only the low halfword of data feeds the merge.
  typedef struct packed {
    st_type_t    typ;
    logic [15:0] data;
  } req_lat_t;

  // Circular left rotate by whole bytes; the inverse of the load path's LWRR.
  function automatic logic [31:0] rotl32(input logic [31:0] d, input logic [1:0] byteshift);
    case (byteshift)
      2'd0:    rotl32 = d;
      2'd1:    rotl32 = {d[23:0], d[31:24]};
      2'd2:    rotl32 = {d[15:0], d[31:16]};
      default: rotl32 = {d[7:0],  d[31:8]};
    endcase
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge of a byte/halfword into a little-endian read word.
// Zero latency; no flow control.
module store_merge
  import store_pkg::*;
(
  input  st_type_t    typ,
  input  logic [1:0]  lane,
  input  logic [15:0] data,
  input  logic [31:0] rdata,
  output logic [31:0] merged
);

  always_comb begin
    merged = rdata;
    case (typ)
      ST_SB:   merged[8*lane +: 8]     = data[7:0];
      ST_SH:   merged[16*lane[1] +: 16] = data[15:0];
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit: SW/SWRR write in 2 cycles, SH/SB read-modify-write in 4, misaligned -> err in 2.
// req_ready only in IDLE (no buffering); STORE_TRACE_EN enables a write trace print.
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_type,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [31:0]       req_pc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  state_t            state, state_nxt;
  logic              init_q;
  req_lat_t          lat;
  logic [ADDR_W+1:0] lat_addr;
  logic [31:0]       wdata_q;
  logic [31:0]       merged;
  logic              accept;
  logic              misaligned;
  st_type_t          in_type;
  logic              unused_bits;

  assign in_type = st_type_t'(req_type);
  assign accept  = req_valid && req_ready;

  always_comb begin
    misaligned = 1'b0;
    case (in_type)
      ST_SW:   misaligned = (req_addr[1:0] != 2'b00);
      ST_SH:   misaligned = req_addr[0];
      default: misaligned = 1'b0;
    endcase
  end

  store_merge u_merge (
    .typ    (lat.typ),
    .lane   (lat_addr[1:0]),
    .data   (lat.data),
    .rdata  (mem_rdata),
    .merged (merged)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      init_q   <= 1'b0;
      lat      <= '0;
      lat_addr <= '0;
      wdata_q  <= '0;
    end else begin
      state  <= state_nxt;
      init_q <= 1'b1;
      if (accept) begin
        lat.typ  <= in_type;
        lat.data <= req_data[15:0];
        lat_addr <= req_addr[ADDR_W+1:0];
        // Full-word stores know their write data at acceptance.
        wdata_q  <= (in_type == ST_SWRR) ? rotl32(req_data, req_addr[1:0]) : req_data;
      end else if (state == S_MRG) begin
        wdata_q <= merged;
      end
    end
  end

  // Outputs come only from registered state; reset gating keeps a mid-flight abort silent.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        req_ready = init_q;
        if (accept) begin
          if (misaligned)
            state_nxt = S_ERR;
          else if (in_type == ST_SW || in_type == ST_SWRR)
            state_nxt = S_WR;
          else
            state_nxt = S_RD;
        end
      end
      S_RD: begin
        busy      = 1'b1;
        mem_re    = 1'b1;
        state_nxt = S_MRG;
      end
      S_MRG: begin
        busy      = 1'b1;
        state_nxt = S_WR;
      end
      S_WR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        busy      = 1'b1;
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (reset) begin
      mem_addr  = lat_addr[ADDR_W+1:2];
      mem_wdata = wdata_q;
    end else begin
      req_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
    end
  end

`ifdef STORE_TRACE_EN
  logic [31:0] lat_pc;

  always_ff @(posedge clk) begin
    if (!reset)
      lat_pc <= '0;
    else if (accept)
      lat_pc <= req_pc;
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      $display("@%08h: *%08h <= %08h", lat_pc,
               {{(30-ADDR_W){1'b0}}, mem_addr, 2'b00}, mem_wdata);
  end

  assign unused_bits = ^req_addr[31:ADDR_W+2];
`else
  assign unused_bits = ^{req_addr[31:ADDR_W+2], req_pc};
`endif

endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Store-side memory access unit: the writer counterpart of the load path's byte-rotate (LWRR) alignment logic. It accepts one store request per handshake from the datapath and performs word, halfword, byte or rotated-word (SWRR) stores into a word-wide data memory that has no byte enables. Partial stores use a read-modify-write sequence. SWRR rotates the word so that a later LWRR from the same byte address returns the original register value.

## Interface
- ADDR_W, 10, word-address width of data memory (1024 words)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_type  in  2  00 SW, 01 SH, 10 SB, 11 SWRR
- req_addr  in  32  byte address
- req_data  in  32  store data from the register file (rt)
- req_pc  in  32  PC of the store instruction (trace only)
- busy  out  1  request in flight (state != IDLE)
- done  out  1  one-cycle pulse, coincident with the memory write
- err  out  1  one-cycle pulse on a misaligned SW/SH; no memory access
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2] (latched)
- mem_re  out  1  memory read strobe; mem_rdata is valid one cycle later
- mem_rdata  in  32  memory read data
- mem_we  out  1  memory write strobe (sampled by memory at the clk edge)
- mem_wdata  out  32  full-word write data

## Operation
- States: IDLE, RD, MRG, WR, ERR.
- IDLE:
  - req_valid && req_ready latches type, addr, data and pc.
  - Next state: ERR if misaligned; WR for SW/SWRR; RD for SH/SB.
- Misaligned cases: SW with addr[1:0]!=0; SH with addr[0]=1. SB and SWRR are never misaligned.
- RD: mem_re=1, mem_addr = latched word address → MRG.
- MRG: capture mem_rdata, form the merged word (little-endian lanes) → WR.
  - SB: lane addr[1:0] (bits 8k+7:8k) ← data[7:0]; other lanes keep rdata.
  - SH: half addr[1] (bits 16h+15:16h) ← data[15:0]; other half keeps rdata.
- WR: mem_we=1, done=1 → IDLE.
  - SW: mem_wdata = data.
  - SWRR: mem_wdata = rotate-left(data, 8*addr[1:0]); aligned word address; no read.
  - SH/SB: mem_wdata = merged word.
- ERR: err=1, no mem_re or mem_we → IDLE.
- New requests are not accepted while busy. req_valid held high is accepted on the first cycle back in IDLE.
- Rotation arithmetic is 32-bit circular: shift of 0 is the identity; shift of 24 moves byte 0 to byte 3.

## Timing
- Reset values while reset=0:
  - State IDLE; all latches 0.
  - req_ready=0, busy=0, done=0, err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
- req_ready=1 from the first cycle after reset deasserts.
- Acceptance at edge T:
  - SW/SWRR: mem_we and done in cycle T+1. Total 2 cycles, back in IDLE at T+2.
  - SH/SB: mem_re in T+1, mem_rdata sampled in T+2, mem_we and done in T+3. Back in IDLE at T+4.
  - Misaligned: err in T+1, IDLE at T+2.
- Reset asserted mid-operation (RD/MRG/WR):
  - Aborts; no mem_we in or after the reset cycle.
  - A partially merged store is discarded.
- Outputs mem_* and done/err are decoded from registered state and latches; no combinational path from req_* to mem_*.

## Configuration
- STORE_TRACE_EN defined:
  - On every cycle with mem_we=1, the simulator prints "@<pc>: *<byteaddr> <= <wdata>".
  - byteaddr = {mem_addr,2'b00} zero-extended to 32 bits. Values are 8-digit hex.
- STORE_TRACE_EN undefined:
  - No $display.
  - req_pc and its latch may be optimized away. Functional behaviour is identical.

## Structure
- Shared package store_pkg:
  - req_type encodings (ST_SW, ST_SH, ST_SB, ST_SWRR).
  - State encoding enum.
  - Function rotl32(data, byteshift).
- Sub-module store_merge: combinational lane merge (type, addr[1:0], data, rdata → merged word). The FSM stays in store_rmw_unit.

## Test plan
- SW, addr 0x0000_0008, data 0x1234_5678:
  - mem_we at T+1, mem_addr=2, mem_wdata 0x1234_5678, done pulse.
  - No mem_re.
- SB, addr 0x0000_0005, data 0xFFFF_FFAB; memory word 1 = 0x1122_3344:
  - mem_re at T+1, write at T+3.
  - mem_wdata 0x1122_AB44.
- SH, addr 0x0000_0006, data 0x0000_BEEF; word 1 = 0x1122_3344:
  - mem_wdata 0xBEEF_3344.
- SWRR, addr 0x0000_0011, data 0xAABB_CCDD:
  - mem_addr=4, mem_wdata 0xBBCC_DDAA, no read.
  - A subsequent LWRR from 0x11 returns 0xAABB_CCDD.
- SW at 0x0000_0002 and SH at 0x0000_0003:
  - err pulse at T+1; mem_we never asserted; req_ready back high at T+2.
- SB accepted, reset driven low during MRG:
  - No mem_we.
  - All outputs at reset values next cycle.
  - A request after release completes normally.
